// File: rtl/pll_seq_pkg.sv
// Shared types, default cycle counts and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } seq_state_t;

    localparam int unsigned DEF_NUM_DOM     = 3;
    localparam int unsigned DEF_ARST_CYC    = 16;
    localparam int unsigned DEF_TIMEOUT_CYC = 65536;
    localparam int unsigned DEF_STABLE_CYC  = 1024;
    localparam int unsigned DEF_STAGE_CYC   = 256;
    localparam int unsigned DEF_MAX_RETRY   = 3;

    // Bits needed to hold values 0..max_val (never less than 1).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Largest of three counts, used to size a shared counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, async active-high reset to 0. Shared by other CDC bits.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops to settle an asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset / lock supervisor with staged release of per-domain active-low resets.
// Runs on the board reference clock. Optional macro LOL_RECOVERY_EN: when defined,
// loss of lock while in RUN drops all domain resets and re-waits for lock.
// Timing constant: with lock present from reset, dom_rst_n[0] rises on rising clk
// edge number ARST_CYC + STABLE_CYC + 2, counting the first edge after rst falls as 1.
// Loss of lock is acted on at the edge after lock_s is seen low.
module pll_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOM     = DEF_NUM_DOM,
    parameter int unsigned ARST_CYC    = DEF_ARST_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned STABLE_CYC  = DEF_STABLE_CYC,
    parameter int unsigned STAGE_CYC   = DEF_STAGE_CYC,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           locked,
    input  logic                           restart,
    output logic                           pll_areset,
    output logic [NUM_DOM-1:0]             dom_rst_n,
    output logic                           seq_done,
    output logic                           seq_fail,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

    localparam int unsigned CNT_W = cnt_w(max3(ARST_CYC, STABLE_CYC, STAGE_CYC));
    localparam int unsigned TMO_W = cnt_w(TIMEOUT_CYC);
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [NUM_DOM-1:0] DOM_FIRST = NUM_DOM'(1);
    localparam logic [NUM_DOM-1:0] DOM_ALL   = '1;

    seq_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              lock_s;
    logic [NUM_DOM-1:0] dom_shift;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    // Next release pattern: one more domain out of reset, lowest index first.
    assign dom_shift = (dom_rst_n << 1) | DOM_FIRST;

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PLL_RST;
            cnt        <= '0;
            tmo_cnt    <= '0;
            pll_areset <= 1'b1;
            dom_rst_n  <= '0;
            seq_done   <= 1'b0;
            seq_fail   <= 1'b0;
            retry_cnt  <= '0;
        end else if (restart) begin
            state      <= PLL_RST;
            cnt        <= '0;
            tmo_cnt    <= '0;
            pll_areset <= 1'b1;
            dom_rst_n  <= '0;
            seq_done   <= 1'b0;
            seq_fail   <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == CNT_W'(ARST_CYC - 1)) begin
                        state      <= WAIT_LOCK;
                        pll_areset <= 1'b0;
                        cnt        <= '0;
                        tmo_cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        tmo_cnt    <= '0;
                        pll_areset <= 1'b1;
                        if (retry_cnt == RTY_W'(MAX_RETRY - 1)) begin
                            state     <= FAIL;
                            seq_fail  <= 1'b1;
                            retry_cnt <= RTY_W'(MAX_RETRY);
                        end else begin
                            state     <= PLL_RST;
                            cnt       <= '0;
                            retry_cnt <= retry_cnt + RTY_W'(1);
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                STABLE: begin
                    // Timeout count is kept so a flapping lock still times out.
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                    end else if (cnt == CNT_W'(STABLE_CYC)) begin
                        dom_rst_n <= DOM_FIRST;
                        cnt       <= '0;
                        if (DOM_FIRST == DOM_ALL) begin
                            state    <= RUN;
                            seq_done <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        dom_rst_n <= '0;
                    end else if (cnt == CNT_W'(STAGE_CYC - 1)) begin
                        cnt       <= '0;
                        dom_rst_n <= dom_shift;
                        if (dom_shift == DOM_ALL) begin
                            state    <= RUN;
                            seq_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
`ifdef LOL_RECOVERY_EN
                    if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        dom_rst_n <= '0;
                        seq_done  <= 1'b0;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                    end
`else
                    state <= RUN;
`endif
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state      <= PLL_RST;
                    cnt        <= '0;
                    pll_areset <= 1'b1;
                    dom_rst_n  <= '0;
                    seq_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed bring-up scenarios plus randomized lock/restart/rst
// traffic, every cycle compared against a phase-level behavioural model.
module tb_pll_rst_seq;

    localparam int NUM_DOM     = 3;
    localparam int ARST_CYC    = 4;
    localparam int TIMEOUT_CYC = 32;
    localparam int STABLE_CYC  = 8;
    localparam int STAGE_CYC   = 4;
    localparam int MAX_RETRY   = 2;

    localparam int M_ARST = 0, M_WAIT = 1, M_STAB = 2, M_REL = 3, M_RUN = 4, M_FAIL = 5;

    logic       clk;
    logic       rst = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_areset;
    logic [2:0] dom_rst_n;
    logic       seq_done;
    logic       seq_fail;
    logic [1:0] retry_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int edge_no  = 0;

    // Model: phase, cycles spent in phase, wait-for-lock time, retries, domains released.
    int   m_ph, m_n, m_t, m_retry, m_nrel;
    logic m_s1, m_s2;

    pll_rst_seq #(
        .NUM_DOM     (NUM_DOM),
        .ARST_CYC    (ARST_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .STABLE_CYC  (STABLE_CYC),
        .STAGE_CYC   (STAGE_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .locked     (locked),
        .restart    (restart),
        .pll_areset (pll_areset),
        .dom_rst_n  (dom_rst_n),
        .seq_done   (seq_done),
        .seq_fail   (seq_fail),
        .retry_cnt  (retry_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, edge_no, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return 32'({pll_areset, seq_done, seq_fail, retry_cnt, dom_rst_n});
    endfunction

    function automatic logic [31:0] model_outs();
        logic [2:0] d;
        d = 3'((1 << m_nrel) - 1);
        return 32'({(m_ph == M_ARST || m_ph == M_FAIL), (m_ph == M_RUN), (m_ph == M_FAIL),
                    2'(m_retry), d});
    endfunction

    task automatic model_reset();
        m_ph = M_ARST; m_n = 0; m_t = 0; m_retry = 0; m_nrel = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
    endtask

    // One reference-clock edge of the sequencing rules.
    task automatic model_step(input logic lk, input logic rs);
        logic ls;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        if (rs) begin
            m_ph = M_ARST; m_n = 0; m_t = 0; m_retry = 0; m_nrel = 0;
        end else begin
            case (m_ph)
                M_ARST: begin
                    m_n++;
                    if (m_n == ARST_CYC) begin m_ph = M_WAIT; m_t = 0; end
                end
                M_WAIT: begin
                    if (ls) begin
                        m_ph = M_STAB; m_n = 0;
                    end else begin
                        m_t++;
                        if (m_t == TIMEOUT_CYC) begin
                            m_t = 0;
                            m_retry++;
                            if (m_retry == MAX_RETRY) m_ph = M_FAIL;
                            else begin m_ph = M_ARST; m_n = 0; end
                        end
                    end
                end
                M_STAB: begin
                    if (!ls) m_ph = M_WAIT;
                    else if (m_n == STABLE_CYC) begin
                        m_nrel = 1; m_n = 0;
                        m_ph = (m_nrel == NUM_DOM) ? M_RUN : M_REL;
                    end else m_n++;
                end
                M_REL: begin
                    if (!ls) begin m_ph = M_WAIT; m_nrel = 0; end
                    else begin
                        m_n++;
                        if (m_n == STAGE_CYC) begin
                            m_n = 0; m_nrel++;
                            if (m_nrel == NUM_DOM) m_ph = M_RUN;
                        end
                    end
                end
                M_RUN: begin
`ifdef LOL_RECOVERY_EN
                    if (!ls) begin m_ph = M_WAIT; m_nrel = 0; m_retry = 0; m_t = 0; end
`endif
                end
                default: ;
            endcase
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic tick(input logic lk, input logic rs);
        locked  = lk;
        restart = rs;
        model_step(lk, rs);
        @(negedge clk);
        edge_no++;
        restart = 1'b0;
        chk("outs", dut_outs(), model_outs());
    endtask

    // Assert rst away from any edge, confirm outputs reset without a clock, release at a falling edge.
    task automatic reset_seq(input logic lk);
        #2 rst = 1'b1;
        #1 chk("async_rst", dut_outs(), 32'h80);
        model_reset();
        locked  = lk;
        restart = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        edge_no = 0;
        chk("reset_vals", dut_outs(), 32'h80);
    endtask

    initial begin : main
        int   e[3];
        int   pa_edge, rise2, rel_edge, run_left;
        logic prev, found, lk;

        // Normal bring-up with lock present throughout.
        reset_seq(1'b1);
        e[0] = -1; e[1] = -1; e[2] = -1; pa_edge = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0);
            for (int b = 0; b < 3; b++)
                if (e[b] < 0 && dom_rst_n[b]) e[b] = edge_no;
            if (pa_edge < 0 && !pll_areset) pa_edge = edge_no;
        end
        chk("areset_fall_edge", 32'(pa_edge), 32'(ARST_CYC));
        chk("rel0_edge", 32'(e[0]), 32'(ARST_CYC + STABLE_CYC + 2));
        chk("rel1_spacing", 32'(e[1] - e[0]), 32'(STAGE_CYC));
        chk("rel2_spacing", 32'(e[2] - e[1]), 32'(STAGE_CYC));
        chk("run_dom", 32'(dom_rst_n), 32'h7);
        chk("run_done", 32'(seq_done), 32'h1);

        // Lock never arrives: two reset pulses, then FAIL.
        reset_seq(1'b0);
        rise2 = -1; prev = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick(1'b0, 1'b0);
            if (rise2 < 0 && !prev && pll_areset) rise2 = edge_no;
            prev = pll_areset;
        end
        chk("areset_rise2_edge", 32'(rise2), 32'(ARST_CYC + TIMEOUT_CYC));
        chk("fail_flag", 32'(seq_fail), 32'h1);
        chk("fail_retry", 32'(retry_cnt), 32'(MAX_RETRY));
        chk("fail_dom", 32'(dom_rst_n), 32'h0);
        chk("fail_areset", 32'(pll_areset), 32'h1);

        // Restart out of FAIL, then full bring-up.
        tick(1'b1, 1'b1);
        chk("restart_fail_clr", 32'(seq_fail), 32'h0);
        chk("restart_retry_clr", 32'(retry_cnt), 32'h0);
        chk("restart_areset", 32'(pll_areset), 32'h1);
        for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
        chk("restart_run", 32'(seq_done), 32'h1);

        // One-cycle lock glitch late in STABLE restarts the stable count.
        reset_seq(1'b1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        rel_edge = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 1'b0);
            if (rel_edge < 0 && dom_rst_n[0]) rel_edge = edge_no;
        end
        chk("glitch_rel_delayed", 32'(rel_edge >= ARST_CYC + 2 * STABLE_CYC + 2), 32'h1);

        // Loss of lock mid-release, then re-release.
        reset_seq(1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1'b1, 1'b0);
            if (dom_rst_n == 3'b011) found = 1'b1;
        end
        chk("reach_011", 32'(found), 32'h1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        chk("lol_rel_dom", 32'(dom_rst_n), 32'h0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1'b1, 1'b0);
            if (seq_done) found = 1'b1;
        end
        chk("rerelease_done", 32'(found), 32'h1);

        // Loss of lock in RUN.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
`ifdef LOL_RECOVERY_EN
        chk("run_lol_dom", 32'(dom_rst_n), 32'h0);
        chk("run_lol_done", 32'(seq_done), 32'h0);
`else
        chk("run_lol_dom", 32'(dom_rst_n), 32'h7);
        chk("run_lol_done", 32'(seq_done), 32'h1);
`endif

        // rst asserted mid-release (async check inside reset_seq).
        reset_seq(1'b1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1'b1, 1'b0);
            if (dom_rst_n == 3'b001) found = 1'b1;
        end
        chk("reach_001", 32'(found), 32'h1);
        reset_seq(1'b1);

        // Randomized bursts of lock/no-lock with occasional restart and rst.
        lk = 1'b1;
        run_left = 0;
        for (int c = 0; c < 5000; c++) begin
            if (run_left == 0) begin
                lk = ~lk;
                if (lk) run_left = int'($urandom_range(1, 60));
                else if ($urandom_range(0, 3) == 0) run_left = int'($urandom_range(40, 90));
                else run_left = int'($urandom_range(1, 6));
            end
            run_left--;
            if ($urandom_range(0, 499) == 0) reset_seq(lk);
            else tick(lk, ($urandom_range(0, 149) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
